// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: tracks EX/MEM/WB in a private scoreboard and drives
// stall/bubble/flush/freeze controls. Optional macro FORWARD_EN: load-use-only interlock.
module hazard_sched #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic                  id_rs1_re_i,
  input  logic                  id_rs2_re_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rd_we_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_mem_re_i,
  input  logic                  id_mem_we_i,
  input  logic                  ex_redirect_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_stall_o,
  output logic                  ifid_stall_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  freeze_o,
  output logic                  mem_wait_o
);

  typedef struct packed {
    logic                  v;
    logic                  rd_we;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_re;
    logic                  mem_we;
  } slot_t;

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  localparam int SLOTS = 3;  // 0 = EX, 1 = MEM, 2 = WB

  slot_t [SLOTS-1:0] sb;
  slot_t             id_slot;
  state_t            state, state_nx;
  logic [SLOTS-1:0]  raw;
  logic              hazard, mem_pend, freeze, bubble;

  for (genvar i = 0; i < SLOTS; i++) begin : g_raw
    assign raw[i] = sb[i].v & sb[i].rd_we & (sb[i].rd != '0) &
                    ((id_rs1_re_i & (id_rs1_i == sb[i].rd)) |
                     (id_rs2_re_i & (id_rs2_i == sb[i].rd)));
  end

`ifdef FORWARD_EN
  assign hazard = id_valid_i & raw[0] & sb[0].mem_re;
`else
  // No bypass: consumer waits until the producer has written the register file.
  assign hazard = id_valid_i & (|raw);
`endif

  assign mem_pend = sb[1].v & (sb[1].mem_re | sb[1].mem_we);
  assign freeze   = mem_pend & ~dmem_ready_i;
  assign bubble   = ~freeze & (ex_redirect_i | hazard);

  always_comb begin
    id_slot        = '0;
    id_slot.v      = id_valid_i & ~bubble;
    id_slot.rd_we  = id_rd_we_i;
    id_slot.rd     = id_rd_i;
    id_slot.mem_re = id_mem_re_i;
    id_slot.mem_we = id_mem_we_i;
    if (!id_slot.v) id_slot = '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (freeze)       state_nx = MEM_WAIT;
      MEM_WAIT: if (dmem_ready_i) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    pc_stall_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    mem_wait_o    = 1'b0;
    if (!rst) begin
      mem_wait_o = (state == MEM_WAIT);
      if (freeze) begin
        freeze_o = 1'b1;
      end else if (ex_redirect_i) begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (hazard) begin
        pc_stall_o    = 1'b1;
        ifid_stall_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb    <= '0;
      state <= IDLE;
    end else begin
      state <= state_nx;
      if (!freeze) begin
        sb[2] <= sb[1];
        sb[1] <= sb[0];
        sb[0] <= id_slot;
      end
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed cycle table, reset corner case, then random
// traffic checked against an in-flight-history reference model.
module tb_hazard_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid_i = 0, id_rs1_re_i = 0, id_rs2_re_i = 0;
  logic [4:0] id_rs1_i = 0, id_rs2_i = 0, id_rd_i = 0;
  logic id_rd_we_i = 0, id_mem_re_i = 0, id_mem_we_i = 0;
  logic ex_redirect_i = 0, dmem_ready_i = 1;
  logic pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, freeze_o, mem_wait_o;

  hazard_sched #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_we_i(id_rd_we_i), .id_rd_i(id_rd_i),
    .id_mem_re_i(id_mem_re_i), .id_mem_we_i(id_mem_we_i),
    .ex_redirect_i(ex_redirect_i), .dmem_ready_i(dmem_ready_i),
    .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o), .mem_wait_o(mem_wait_o)
  );

  always #5 clk = ~clk;

  // want = {pc_stall, ifid_stall, ifid_flush, idex_bubble, freeze, mem_wait}
  typedef struct {
    logic v, r1e; logic [4:0] r1; logic r2e; logic [4:0] r2;
    logic we; logic [4:0] rd; logic mre, mwe, redir, rdy;
    logic [5:0] want;
  } vec_t;

  typedef struct packed {logic v, we; logic [4:0] rd; logic mre, mwe;} m_t;

  vec_t vecs[$];
  m_t   hist[$];    // in-flight instructions, youngest (EX) first
  bit   prev_frz;
  int   checks = 0, errors = 0;

  function automatic logic [5:0] got();
    return {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, freeze_o, mem_wait_o};
  endfunction

  task automatic check(input string name, input logic [5:0] want);
    checks++;
    if (got() !== want) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got(), want);
    end
  endtask

  task automatic push(input logic v, r1e, input logic [4:0] r1, input logic r2e,
                      input logic [4:0] r2, input logic we, input logic [4:0] rd,
                      input logic mre, mwe, redir, rdy, input logic [5:0] want);
    vec_t t;
    t.v = v; t.r1e = r1e; t.r1 = r1; t.r2e = r2e; t.r2 = r2; t.we = we; t.rd = rd;
    t.mre = mre; t.mwe = mwe; t.redir = redir; t.rdy = rdy; t.want = want;
    vecs.push_back(t);
  endtask

  task automatic nop(input logic redir, rdy, input logic [5:0] want);
    push(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, redir, rdy, want);
  endtask

  task automatic drive(input vec_t t);
    id_valid_i = t.v; id_rs1_re_i = t.r1e; id_rs1_i = t.r1; id_rs2_re_i = t.r2e;
    id_rs2_i = t.r2; id_rd_we_i = t.we; id_rd_i = t.rd; id_mem_re_i = t.mre;
    id_mem_we_i = t.mwe; ex_redirect_i = t.redir; dmem_ready_i = t.rdy;
  endtask

  function automatic bit needs(input m_t s);
    return s.v && s.we && s.rd != 0 &&
           ((id_rs1_re_i && id_rs1_i == s.rd) || (id_rs2_re_i && id_rs2_i == s.rd));
  endfunction

  function automatic bit m_freeze();
    return hist[1].v && (hist[1].mre || hist[1].mwe) && !dmem_ready_i;
  endfunction

  function automatic bit m_hazard();
    bit h = 0;
`ifdef FORWARD_EN
    h = needs(hist[0]) && hist[0].mre;
`else
    foreach (hist[i]) if (needs(hist[i])) h = 1;
`endif
    return id_valid_i && h;
  endfunction

  function automatic logic [5:0] model_out();
    logic [5:0] o = {5'b0, prev_frz};
    if (m_freeze())         o[1] = 1;
    else if (ex_redirect_i) o[3:2] = 2'b11;
    else if (m_hazard())    o[5:2] = 4'b1101;
    return o;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
    prev_frz = 0;
  endtask

  task automatic model_step();
    m_t n = '0;
    bit frz = m_freeze();
    if (!frz) begin
      if (id_valid_i && !ex_redirect_i && !m_hazard())
        n = '{1'b1, id_rd_we_i, id_rd_i, id_mem_re_i, id_mem_we_i};
      hist.push_front(n);
      void'(hist.pop_back());
    end
    prev_frz = frz;
  endtask

  initial begin
    // x0 destination never interlocks
    push(1, 1, 5'd1, 0, 5'd0, 1, 5'd0, 0, 0, 0, 1, 6'b000000);
    push(1, 1, 5'd0, 1, 5'd0, 1, 5'd1, 0, 0, 0, 1, 6'b000000);
    repeat (3) nop(0, 1, 6'b000000);
    // lw x5 ; add x6,x5,x1
    push(1, 1, 5'd2, 0, 5'd0, 1, 5'd5, 1, 0, 0, 1, 6'b000000);
`ifdef FORWARD_EN
    push(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0, 0, 1, 6'b110100);
`else
    repeat (3) push(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0, 0, 1, 6'b110100);
`endif
    push(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0, 0, 1, 6'b000000);
    repeat (3) nop(0, 1, 6'b000000);
    // redirect kills the load; the dependent add sees an empty EX
    push(1, 1, 5'd2, 0, 5'd0, 1, 5'd5, 1, 0, 1, 1, 6'b001100);
    push(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0, 0, 1, 6'b000000);
    repeat (3) nop(0, 1, 6'b000000);
    // load-use together with redirect: redirect wins
    push(1, 1, 5'd2, 0, 5'd0, 1, 5'd5, 1, 0, 0, 1, 6'b000000);
    push(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0, 1, 1, 6'b001100);
    repeat (3) nop(0, 1, 6'b000000);
    // sw waits 4 cycles in MEM; redirect held across the freeze
    push(1, 1, 5'd2, 1, 5'd3, 0, 5'd0, 0, 1, 0, 1, 6'b000000);
    nop(0, 1, 6'b000000);
    nop(0, 0, 6'b000010);
    nop(0, 0, 6'b000011);
    nop(1, 0, 6'b000011);
    nop(1, 0, 6'b000011);
    nop(1, 1, 6'b001101);
    nop(0, 0, 6'b000000);

    #2 check("reset_outputs", 6'b000000);
    @(posedge clk); #1 rst = 0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk) check($sformatf("vec%0d", i), vecs[i].want);
      @(posedge clk); #1;
    end

    // reset asserted while a load-use stall is in progress
    push(1, 1, 5'd2, 0, 5'd0, 1, 5'd5, 1, 0, 0, 1, 6'b000000);
    drive(vecs[$]);
    @(negedge clk) check("ld_issue", 6'b000000);
    @(posedge clk); #1;
    push(1, 1, 5'd5, 0, 5'd0, 1, 5'd6, 0, 0, 0, 1, 6'b110100);
    drive(vecs[$]);
    @(negedge clk) check("ld_use_stall", 6'b110100);
    rst = 1;
    #1 check("rst_mid_hazard", 6'b000000);
    @(posedge clk); #1 rst = 0;
    @(negedge clk) check("post_rst_no_stall", 6'b000000);

    rst = 1;
    @(posedge clk); #1 rst = 0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int k = $urandom % 4;
      id_valid_i    = ($urandom % 8) != 0;
      id_rs1_re_i   = $urandom % 2; id_rs1_i = 5'($urandom_range(0, 3));
      id_rs2_re_i   = $urandom % 2; id_rs2_i = 5'($urandom_range(0, 3));
      id_rd_i       = 5'($urandom_range(0, 3));
      id_mem_re_i   = (k == 0);
      id_mem_we_i   = (k == 1);
      id_rd_we_i    = (k == 0) || (k >= 2 && ($urandom % 4) != 0);
      ex_redirect_i = ($urandom % 8) == 0;
      dmem_ready_i  = ($urandom % 3) != 0;
      if (($urandom % 100) == 0) begin
        rst = 1;
        #1 check($sformatf("rnd_rst%0d", c), 6'b000000);
        @(posedge clk); #1 rst = 0;
        model_reset();
      end else begin
        @(negedge clk) check($sformatf("rnd%0d", c), model_out());
        model_step();
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
